// File: rtl/jtframe_rom_arb.sv
// Purpose: four-slot ROM read cache that arbitrates SDRAM reads round-robin.
// Latency: a hit shows on slot_ok one cycle later; a miss raises sdram_req one cycle later.
// Backpressure: holds sdram_req/sdram_addr until sdram_ack, then waits for data_rdy.
//
// Ports:
//   clk_rom, rst_n          clock, asynchronous active-low reset
//   downloading             ROM load in progress: flushes the cache and blocks new grants
//   slot_cs/slot_addr       per-slot read request and address (slot i at [i*AW +: AW])
//   slot_ok/slot_dout       per-slot hit flag and cached data (slot i at [i*DW +: DW])
//   sdram_req/sdram_addr    read request towards the SDRAM controller
//   sdram_ack               controller took the request (one-cycle pulse)
//   data_rdy/data_read      read data return (one-cycle pulse)
module jtframe_rom_arb #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            clk_rom,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [3:0]      slot_cs,
  input  logic [4*AW-1:0] slot_addr,
  output logic [3:0]      slot_ok,
  output logic [4*DW-1:0] slot_dout,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [DW-1:0]   data_read
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [3:0]    valid;
  logic [AW-1:0] tag  [4];
  logic [DW-1:0] data [4];
  logic [AW-1:0] addr [4];
  logic [1:0]    sel;
  logic [1:0]    last;
  logic [3:0]    hit;
  logic [3:0]    miss;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [1:0]    idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = slot_addr[i*AW +: AW];
      hit[i]  = slot_cs[i] & valid[i] & (addr[i] == tag[i]) & ~downloading;
      miss[i] = slot_cs[i] & ~hit[i];
    end
  end

  // Round-robin search starting just after the last filled slot; the
  // 2-bit add wraps, so the fourth candidate is 'last' itself.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    idx      = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_vld && miss[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dout
    assign slot_dout[g*DW +: DW] = data[g];
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= '0;
      valid      <= '0;
      sel        <= '0;
      last       <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      slot_ok <= hit;
      if (downloading) valid <= '0;
      case (state)
        IDLE: begin
          if (!downloading && pick_vld) begin
            sel        <= pick;
            sdram_addr <= addr[pick];
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // data_rdy in this state is ignored even if it coincides with ack
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Fill with the latched address, not the live slot address, so a
          // slot that moved on simply misses again next cycle.
          if (data_rdy) begin
            tag[sel]   <= sdram_addr;
            data[sel]  <= data_read;
            valid[sel] <= ~downloading;
            last       <= sel;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
